// File: rtl/avalon_mm_resp_slave.sv
// Avalon-MM slave responder backed by a byte-addressed internal memory.
// Single-beat reads and writes, programmable waitrequest stall per command,
// fixed-latency in-order readdatavalid pipeline, bounded reads in flight.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address             byte address (wraps modulo 2**ADDR_W)
//   read, write         command strobes
//   writedata           write data
//   byteenable          write qualifier; 0 accepts the write but stores nothing
//   waitrequest         stall; command accepted when (read|write) && !waitrequest
//   readdata            read data, meaningful while readdatavalid=1, held otherwise
//   readdatavalid       one-cycle strobe per accepted read
//   protocol_err        sticky flag, read and write seen together
module avalon_mm_resp_slave #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned MAX_PENDING  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              byteenable,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              protocol_err
);

  localparam int unsigned      PendW   = $clog2(MAX_PENDING + 1);
  localparam logic [PendW-1:0] PendMax = PendW'(MAX_PENDING);
  localparam logic [2:0]       WaitMax = 3'(WAIT_CYCLES);

  localparam logic StIdle  = 1'b0;
  localparam logic StStall = 1'b1;

  logic                    state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [PendW-1:0]        pend_q, pend_d;
  logic                    err_q, err_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]       dat_q [READ_LATENCY];
  logic [DATA_W-1:0]       dat_d [READ_LATENCY];

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic req, retire, pend_full, accept, acc_rd, acc_wr;

  assign req       = read | write;
  assign retire    = vld_q[READ_LATENCY-1];
  // A read retiring this cycle frees its slot for a same-cycle accept.
  assign pend_full = (pend_q == PendMax) && !retire;
  assign acc_rd    = accept & read & ~write;
  // On a dual request the write wins and the read is dropped.
  assign acc_wr    = accept & write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waitrequest = 1'b1;
    accept      = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        StIdle: begin
          if (!req) begin
            waitrequest = pend_full;
          end else if (WAIT_CYCLES == 0) begin
            waitrequest = pend_full;
            accept      = !pend_full;
          end else begin
            // This cycle is the first stall cycle.
            state_d = StStall;
            cnt_d   = 3'd1;
          end
        end
        StStall: begin
          if (!req) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end else if (cnt_q == WaitMax) begin
            if (!pend_full) begin
              waitrequest = 1'b0;
              accept      = 1'b1;
              state_d     = StIdle;
              cnt_d       = 3'd0;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (acc_rd && !retire) begin
      pend_d = pend_q + PendW'(1);
    end else if (!acc_rd && retire) begin
      pend_d = pend_q - PendW'(1);
    end
    err_d = err_q | (read & write);

    // Data registers load only with a valid token so the output holds.
    vld_d[0] = acc_rd;
    dat_d[0] = acc_rd ? mem[address] : dat_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Storage is not reset; acc_wr is already gated by reset_n.
  always_ff @(posedge clk) begin
    if (acc_wr && byteenable) begin
      mem[address] <= writedata;
    end
  end

  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign protocol_err  = err_q;

endmodule

// File: tb/tb_avalon_mm_resp_slave.sv
module tb_avalon_mm_resp_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd   [2];
  logic        wr   [2];
  logic [11:0] ad   [2];
  logic [7:0]  wd   [2];
  logic        be   [2];
  logic        wreq [2];
  logic [7:0]  rdat [2];
  logic        rdv  [2];
  logic        perr [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance 0: one stall cycle per command. Instance 1: no stall.
  avalon_mm_resp_slave #(
    .ADDR_W(12), .DATA_W(8), .READ_LATENCY(3), .WAIT_CYCLES(1), .MAX_PENDING(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(ad[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wd[0]), .byteenable(be[0]), .waitrequest(wreq[0]), .readdata(rdat[0]),
    .readdatavalid(rdv[0]), .protocol_err(perr[0])
  );

  avalon_mm_resp_slave #(
    .ADDR_W(12), .DATA_W(8), .READ_LATENCY(3), .WAIT_CYCLES(0), .MAX_PENDING(2)
  ) dut_nw (
    .clk(clk), .reset_n(reset_n), .address(ad[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wd[1]), .byteenable(be[1]), .waitrequest(wreq[1]), .readdata(rdat[1]),
    .readdatavalid(rdv[1]), .protocol_err(perr[1])
  );

  // Presents a command and holds it until accepted; waits = stalled cycles.
  task automatic cmd(input int s, input logic r, input logic w, input logic [11:0] a,
                     input logic [7:0] d, input logic b, output int waits);
    waits = 0;
    @(negedge clk);
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d; be[s] = b;
    #1;
    while (wreq[s] && waits < 50) begin
      waits++;
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  // lat counts cycles from the accepting edge to the readdatavalid cycle.
  task automatic rd_lat(input int s, input logic [11:0] a, output logic [7:0] data,
                        output int waits, output int lat);
    cmd(s, 1'b1, 1'b0, a, 8'h00, 1'b0, waits);
    lat = 0;
    data = 8'hxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdv[s]) begin
        lat = k;
        data = rdat[s];
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 0; wr[s] = 0; ad[s] = 0; wd[s] = 0; be[s] = 0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (wreq[s] !== 1'b1) begin
        miscompares++; $display("FAIL reset_waitrequest[%0d] got %b exp 1", s, wreq[s]);
      end
      vectors++;
      if (rdv[s] !== 1'b0 || rdat[s] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_read_outputs[%0d] got rdv=%b data=%h exp 0/00", s, rdv[s], rdat[s]);
      end
      vectors++;
      if (perr[s] !== 1'b0) begin
        miscompares++; $display("FAIL reset_protocol_err[%0d] got %b exp 0", s, perr[s]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (wreq[0] !== 1'b0) begin
      miscompares++; $display("FAIL idle_waitrequest got %b exp 0", wreq[0]);
    end
  endtask

  task automatic test_write_read();
    int w, lat;
    logic [7:0] d;
    cmd(0, 1'b0, 1'b1, 12'h010, 8'hA5, 1'b1, w);
    vectors++;
    if (w !== 1) begin
      miscompares++; $display("FAIL wr_stall_cycles got %0d exp 1", w);
    end
    rd_lat(0, 12'h010, d, w, lat);
    vectors++;
    if (w !== 1) begin
      miscompares++; $display("FAIL rd_stall_cycles got %0d exp 1", w);
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++; $display("FAIL rd_latency got %0d exp 3", lat);
    end
    vectors++;
    if (d !== 8'hA5) begin
      miscompares++; $display("FAIL rd_data_010 got %h exp a5", d);
    end
    @(negedge clk);
    vectors++;
    if (rdv[0] !== 1'b0 || rdat[0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_hold got rdv=%b data=%h exp 0/a5", rdv[0], rdat[0]);
    end
  endtask

  task automatic test_byteenable();
    int w, lat;
    logic [7:0] d;
    cmd(0, 1'b0, 1'b1, 12'hFFF, 8'h7E, 1'b1, w);
    cmd(0, 1'b0, 1'b1, 12'hFFF, 8'h00, 1'b0, w);
    vectors++;
    if (w !== 1) begin
      miscompares++; $display("FAIL be0_accepted_stall got %0d exp 1", w);
    end
    rd_lat(0, 12'hFFF, d, w, lat);
    vectors++;
    if (d !== 8'h7E || lat !== 3) begin
      miscompares++; $display("FAIL be0_rd_fff got data=%h lat=%0d exp 7e/3", d, lat);
    end
  endtask

  task automatic test_protocol_err();
    int w, lat, seen;
    logic [7:0] d;
    cmd(0, 1'b1, 1'b1, 12'h020, 8'h5C, 1'b1, w);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdv[0]) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL dual_no_rdv got %0d strobes exp 0", seen);
    end
    vectors++;
    if (perr[0] !== 1'b1) begin
      miscompares++; $display("FAIL dual_protocol_err got %b exp 1", perr[0]);
    end
    rd_lat(0, 12'h020, d, w, lat);
    vectors++;
    if (d !== 8'h5C || lat !== 3) begin
      miscompares++; $display("FAIL dual_write_done got data=%h lat=%0d exp 5c/3", d, lat);
    end
    vectors++;
    if (perr[0] !== 1'b1) begin
      miscompares++; $display("FAIL protocol_err_sticky got %b exp 1", perr[0]);
    end
  endtask

  task automatic test_back_to_back();
    int w0, w1, w2, n;
    logic [7:0] got [4];
    cmd(1, 1'b0, 1'b1, 12'h000, 8'h11, 1'b1, w0);
    cmd(1, 1'b0, 1'b1, 12'h001, 8'h22, 1'b1, w0);
    cmd(1, 1'b0, 1'b1, 12'h002, 8'h33, 1'b1, w0);
    n = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'hxx;
    fork
      begin
        cmd(1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, w0);
        cmd(1, 1'b1, 1'b0, 12'h001, 8'h00, 1'b0, w1);
        cmd(1, 1'b1, 1'b0, 12'h002, 8'h00, 1'b0, w2);
      end
      begin
        for (int k = 0; k < 25; k++) begin
          @(negedge clk);
          if (rdv[1]) begin
            if (n < 4) got[n] = rdat[1];
            n++;
          end
        end
      end
    join
    vectors++;
    if (w0 !== 0 || w1 !== 0) begin
      miscompares++; $display("FAIL b2b_first_two_stall got %0d,%0d exp 0,0", w0, w1);
    end
    vectors++;
    if (w2 !== 1) begin
      miscompares++; $display("FAIL b2b_third_stall got %0d exp 1", w2);
    end
    vectors++;
    if (n !== 3) begin
      miscompares++; $display("FAIL b2b_strobe_count got %0d exp 3", n);
    end
    vectors++;
    if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      miscompares++;
      $display("FAIL b2b_order got %h %h %h exp 11 22 33", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_reset_flush();
    int w, lat, seen;
    logic [7:0] d;
    cmd(1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, w);
    cmd(1, 1'b1, 1'b0, 12'h002, 8'h00, 1'b0, w);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (wreq[0] !== 1'b1 || wreq[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_waitrequest got %b,%b exp 1,1", wreq[0], wreq[1]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdv[1]) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL flush_no_rdv got %0d strobes exp 0", seen);
    end
    vectors++;
    if (perr[0] !== 1'b0 || rdat[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL flush_cleared got perr=%b data=%h exp 0/00", perr[0], rdat[1]);
    end
    rd_lat(1, 12'h001, d, w, lat);
    vectors++;
    if (w !== 0 || lat !== 3 || d !== 8'h22) begin
      miscompares++;
      $display("FAIL flush_next_read got stall=%0d lat=%0d data=%h exp 0/3/22", w, lat, d);
    end
  endtask

  task automatic test_write_then_read();
    int w, lat;
    logic [7:0] d;
    cmd(1, 1'b0, 1'b1, 12'h005, 8'h3C, 1'b1, w);
    rd_lat(1, 12'h005, d, w, lat);
    vectors++;
    if (w !== 0 || lat !== 3) begin
      miscompares++; $display("FAIL wtr_timing got stall=%0d lat=%0d exp 0/3", w, lat);
    end
    vectors++;
    if (d !== 8'h3C) begin
      miscompares++; $display("FAIL wtr_data got %h exp 3c", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byteenable();
    test_protocol_err();
    test_back_to_back();
    test_reset_flush();
    test_write_then_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_mm_resp_slave.md
Name: avalon_mm_resp_slave

Overview:
- Synthesizable Avalon-MM slave responder with byte-addressed internal memory: the far end of the Avalon-MM master that fetches image and coefficient bytes.
- Accepts single-beat reads and writes.
- Inserts programmable waitrequest backpressure and returns read data over a fixed-latency pipelined readdatavalid path.
- Replaces the simulation slave BFM on the FPGA build and serves as the local image/coefficient store.

Parameters:
ADDR_W, 12, byte address width; memory depth 2**ADDR_W bytes
DATA_W, 8, data width (one 8-bit symbol)
READ_LATENCY, 3, cycles from read acceptance to readdatavalid (1..8)
WAIT_CYCLES, 1, waitrequest cycles inserted before each command is accepted (0..7)
MAX_PENDING, 2, max reads in flight (1..READ_LATENCY)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  byte address
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
byteenable  in  1  write enable qualifier; write with byteenable=0 is accepted but stores nothing
waitrequest  out  1  stall; command accepted on rising clk when (read|write) && !waitrequest
readdata  out  DATA_W  read data, valid only when readdatavalid=1
readdatavalid  out  1  one-cycle strobe per accepted read, in order
protocol_err  out  1  sticky; set when read and write are asserted together

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - waitrequest=1 while reset_n=0.
  - readdata=0, readdatavalid=0, protocol_err=0.
  - Wait counter=0, pending count=0, latency pipeline cleared.
  - Memory contents are not reset and are undefined until written.
- Reset mid-operation: all in-flight reads are discarded; no readdatavalid is issued for them after reset.
- Stall FSM:
  - IDLE: no request -> waitrequest=pend_full.
  - Request present with WAIT_CYCLES=0 -> accepted this cycle unless pend_full.
  - Request present with WAIT_CYCLES>0 -> go to STALL, waitrequest=1.
  - STALL: counter increments each cycle while the request is held. When counter==WAIT_CYCLES and !pend_full, waitrequest=0, the command is accepted, the counter clears, and the FSM returns to IDLE.
  - Request dropped during STALL (illegal per protocol): return to IDLE, counter clears, nothing is accepted.
- Back-to-back commands: each command incurs the full WAIT_CYCLES stall. Throughput is one command per WAIT_CYCLES+1 cycles.
- pend_full = (pending==MAX_PENDING) && !retire, where retire=readdatavalid in the current cycle. A same-cycle retire frees a slot.
- Write acceptance: mem[address] <= writedata if byteenable. Visible to any read accepted on a later cycle.
- Read acceptance:
  - mem[address] is sampled into latency stage 1 at acceptance.
  - readdatavalid=1 with that data exactly READ_LATENCY cycles after the accepting edge.
  - pending increments on accept and decrements on retire; both in one cycle leave it unchanged.
- read&write together: the write is performed, the read is dropped (no readdatavalid), and protocol_err=1 until reset.
- Address wraps naturally modulo 2**ADDR_W; no out-of-range response.
- readdata holds its last value when readdatavalid=0.
- Responses are always returned in acceptance order.

Test Plan:
- Write 0xA5 to addr 0x010, then read 0x010 (WAIT_CYCLES=1, READ_LATENCY=3) -> waitrequest high 1 cycle per command; readdatavalid exactly 3 cycles after read acceptance with readdata=0xA5.
- Write 0x11,0x22,0x33 to 0x000..0x002, then 3 back-to-back reads with MAX_PENDING=2, WAIT_CYCLES=0 -> third read stalled until first retires; returns 0x11,0x22,0x33 in order, no gaps lost.
- Write 0x7E to 0xFFF, then write 0x00 with byteenable=0 to 0xFFF, then read 0xFFF -> 0x7E returned.
- read=1 and write=1 at addr 0x020, data 0x5C -> protocol_err=1 sticky; later read of 0x020 returns 0x5C; no readdatavalid for the dual request.
- Two reads in flight, then reset_n pulsed low for 1 cycle -> waitrequest=1 during reset; readdatavalid never asserts for the flushed reads; pending=0 afterward and the next read completes normally.
- Write to 0x005 accepted, then read 0x005 accepted on the very next cycle -> new data returned (write-before-read ordering).
